// File: rtl/hdmi_period_decode.sv
// hdmi_period_decode: classifies TMDS characters into control/guard/video/island periods and recovers sync and pixel strobes.
// Define HDMI_PREAMBLE_CHECK_EN to accept guard bands only after a full counted preamble.
module hdmi_period_decode #(
  parameter int PREAMBLE_LEN = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [9:0] i_ch0,
  input  logic [9:0] i_ch1,
  input  logic [9:0] i_ch2,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_pv,
  output logic       o_island,
  output logic       o_err
);
  localparam logic [9:0] GB_A = 10'b1011001100;
  localparam logic [9:0] GB_B = 10'b0100110011;
  typedef enum logic [2:0] {CONTROL, VGUARD, VIDEO, IGUARD, ISLAND} state_t;
  function automatic logic is_ctl(input logic [9:0] q);
    return q == 10'b1101010100 || q == 10'b0010101011 || q == 10'b0101010100 || q == 10'b1010101011;
  endfunction
  function automatic logic [1:0] ctl_d(input logic [9:0] q);
    return {q == 10'b0101010100 || q == 10'b1010101011, q == 10'b0010101011 || q == 10'b1010101011};
  endfunction
  if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 15) begin : g_len_chk
    $error("PREAMBLE_LEN out of range");
  end
  state_t     state;
  logic       s1_vld, s1_c0, s1_c1, s1_c2, s1_vgb, s1_igb;
  logic [1:0] s1_sync;
  logic       all_ctl, pre_vid, pre_isl;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      s1_vld  <= 1'b0;
      s1_c0   <= 1'b0;
      s1_c1   <= 1'b0;
      s1_c2   <= 1'b0;
      s1_vgb  <= 1'b0;
      s1_igb  <= 1'b0;
      s1_sync <= 2'b00;
    end else begin
      s1_vld  <= 1'b1;
      s1_c0   <= is_ctl(i_ch0);
      s1_c1   <= is_ctl(i_ch1);
      s1_c2   <= is_ctl(i_ch2);
      s1_vgb  <= i_ch0 == GB_A && i_ch1 == GB_B && i_ch2 == GB_A;
      s1_igb  <= i_ch1 == GB_B && i_ch2 == GB_B;
      s1_sync <= ctl_d(i_ch0);
    end
  assign all_ctl = s1_c0 & s1_c1 & s1_c2;
`ifdef HDMI_PREAMBLE_CHECK_EN
  localparam logic [3:0] LEN = 4'(PREAMBLE_LEN);
  logic [3:0] s1_ctl, cnt, prev_ctl;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) s1_ctl <= 4'd0;
    else s1_ctl <= {ctl_d(i_ch2), ctl_d(i_ch1)};
  // cnt == 0 means the previous character was not a control word, so prev_ctl is stale
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      cnt      <= 4'd0;
      prev_ctl <= 4'd0;
    end else if (s1_c1 && s1_c2) begin
      cnt      <= (cnt == 4'd0 || s1_ctl != prev_ctl) ? 4'd1 : (cnt >= LEN ? LEN : cnt + 4'd1);
      prev_ctl <= s1_ctl;
    end else begin
      cnt <= 4'd0;
    end
  assign pre_vid = cnt == LEN && prev_ctl == 4'b0001;
  assign pre_isl = cnt == LEN && prev_ctl == 4'b0101;
`else
  assign pre_vid = 1'b1;
  assign pre_isl = 1'b1;
`endif
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state    <= CONTROL;
      o_hsync  <= 1'b0;
      o_vsync  <= 1'b0;
      o_pv     <= 1'b0;
      o_island <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_pv     <= 1'b0;
      o_island <= 1'b0;
      o_err    <= 1'b0;
      // island payload on ch0 is TERC4, so sync is only trusted when the island ends
      if (s1_c0 && (state != ISLAND || s1_c1)) {o_vsync, o_hsync} <= s1_sync;
      case (state)
        CONTROL:
          if (all_ctl) state <= CONTROL;
          else if (s1_vgb && pre_vid) state <= VGUARD;
          else if (s1_igb && pre_isl) state <= IGUARD;
          else o_err <= s1_vld;
        VGUARD:
          if (s1_vgb) state <= VIDEO;
          else begin
            o_err <= 1'b1;
            state <= CONTROL;
          end
        VIDEO:
          if (s1_c0) state <= CONTROL;
          else o_pv <= 1'b1;
        IGUARD:
          if (s1_igb) state <= ISLAND;
          else begin
            o_err <= 1'b1;
            state <= CONTROL;
          end
        ISLAND:
          if (s1_c1) state <= CONTROL;
          else o_island <= 1'b1;
        default: state <= CONTROL;
      endcase
    end
endmodule

// File: tb/tb_hdmi_period_decode.sv
// tb_hdmi_period_decode: vector table plus directed sequences for video length and mid-video reset.
module tb_hdmi_period_decode;
  localparam logic [9:0] C00 = 10'b1101010100, C01 = 10'b0010101011, C10 = 10'b0101010100;
  localparam logic [9:0] VG0 = 10'b1011001100, GB = 10'b0100110011, IG0 = 10'h1C7;
  localparam logic [9:0] PIX = 10'h3F0, TRC = 10'h29C;
  typedef struct {
    logic [9:0] c0, c1, c2;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[$];
  logic i_clk, i_reset;
  logic [9:0] i_ch0, i_ch1, i_ch2;
  logic o_hsync, o_vsync, o_pv, o_island, o_err;
  logic [4:0] outs;
  int checks = 0, errors = 0, cyc = 0, pv_cnt = 0, err_cnt = 0, first_pv = -1, last_pv = -1, a = 0;
  hdmi_period_decode #(.PREAMBLE_LEN(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ch0(i_ch0), .i_ch1(i_ch1), .i_ch2(i_ch2),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_pv(o_pv), .o_island(o_island), .o_err(o_err)
  );
  assign outs = {o_hsync, o_vsync, o_pv, o_island, o_err};
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  function void add(input int n, input logic [9:0] c0, c1, c2, input logic [4:0] e);
    for (int k = 0; k < n; k++) tbl.push_back('{c0, c1, c2, e});
  endfunction
  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask
  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic step(input logic [9:0] c0, input logic [9:0] c1, input logic [9:0] c2);
    i_ch0 = c0;
    i_ch1 = c1;
    i_ch2 = c2;
    @(posedge i_clk);
    #1;
    cyc++;
    if (o_pv) begin
      pv_cnt++;
      if (first_pv < 0) first_pv = cyc;
      last_pv = cyc;
    end
    if (o_err) err_cnt++;
  endtask
  task automatic clr_mon();
    pv_cnt = 0;
    err_cnt = 0;
    first_pv = -1;
    last_pv = -1;
  endtask
  initial begin
    // outputs packed as {hsync, vsync, pv, island, err}
    add(1, C00, C00, C00, 5'b00000);
    add(4, C01, C00, C00, 5'b10000);
    add(1, C00, C00, C00, 5'b00000);
    add(8, C00, C01, C00, 5'b00000);
    add(2, VG0, GB, VG0, 5'b00000);
    add(4, PIX, PIX, PIX, 5'b00100);
    add(1, C00, C00, C00, 5'b00000);
    add(8, C00, C01, C01, 5'b00000);
    add(2, IG0, GB, GB, 5'b00000);
    add(4, PIX, TRC, TRC, 5'b00010);
    add(2, C10, C00, C00, 5'b01000);
    add(8, C10, C01, C00, 5'b01000);
    add(1, VG0, GB, VG0, 5'b01000);
    add(1, C10, C00, C00, 5'b01001);
    add(1, C00, C00, C00, 5'b00000);
    add(7, C00, C01, C00, 5'b00000);
`ifdef HDMI_PREAMBLE_CHECK_EN
    add(2, VG0, GB, VG0, 5'b00001);
    add(1, PIX, PIX, PIX, 5'b00001);
`else
    add(2, VG0, GB, VG0, 5'b00000);
    add(1, PIX, PIX, PIX, 5'b00100);
`endif
    add(1, C00, C00, C00, 5'b00000);
    i_reset = 1'b1;
    i_ch0 = C00;
    i_ch1 = C00;
    i_ch2 = C00;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_outs", outs, 5'b00000);
    #2 i_reset = 1'b0;
    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size()) step(tbl[i].c0, tbl[i].c1, tbl[i].c2);
      else step(C00, C00, C00);
      if (i == 0) chk("first_out", outs, 5'b00000);
      else chk($sformatf("vec%0d", i - 1), outs, tbl[i-1].exp);
    end
    clr_mon();
    repeat (8) step(C00, C01, C00);
    repeat (2) step(VG0, GB, VG0);
    a = cyc;
    for (int p = 0; p < 640; p++) step(PIX ^ 10'(p & 3), PIX, PIX);
    repeat (3) step(C00, C00, C00);
    chk_i("pv640_count", pv_cnt, 640);
    chk_i("pv640_first", first_pv, a + 2);
    chk_i("pv640_consec", last_pv - first_pv + 1, 640);
    chk_i("pv640_err", err_cnt, 0);
    repeat (8) step(C00, C01, C00);
    repeat (2) step(VG0, GB, VG0);
    repeat (4) step(PIX, PIX, PIX);
    chk("pv_before_rst", {4'b0000, o_pv}, 5'b00001);
    #2 i_reset = 1'b1;
    #1 chk("async_rst_outs", outs, 5'b00000);
    #1 i_reset = 1'b0;
    clr_mon();
    repeat (5) step(PIX, PIX, PIX);
    chk_i("no_pv_after_rst", pv_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hdmi_period_decode.md
# hdmi_period_decode

Upstream stage of the HDMI receive video-mode measurement path. Accepts three word-aligned 10-bit TMDS characters per pixel clock and classifies each into control, guard-band, video or data-island periods. Produces the registered `o_hsync`, `o_vsync` and `o_pv` strobes that the vertical/horizontal mode measurement logic consumes. It also flags protocol errors for the link-status registers.

## Interface

Parameters:
- `PREAMBLE_LEN`, default 8: number of consecutive identical preamble characters required; range 1–15.

Ports:
- `i_clk` input 1: pixel clock; all logic on its rising edge.
- `i_reset` input 1: asynchronous, active-high reset.
- `i_ch0` input 10: TMDS channel 0 (blue) character, bit [9:0] as defined by DVI `q_out`.
- `i_ch1` input 10: TMDS channel 1 (green) character.
- `i_ch2` input 10: TMDS channel 2 (red) character.
- `o_hsync` output 1: recovered horizontal sync level.
- `o_vsync` output 1: recovered vertical sync level.
- `o_pv` output 1: high for each active video pixel.
- `o_island` output 1: high while in a data island.
- `o_err` output 1: one-cycle pulse on a protocol violation.

## Operation

Token classification, per channel:
- Control tokens, with {D1,D0} mapping:
  - 00 = 1101010100
  - 01 = 0010101011
  - 10 = 0101010100
  - 11 = 1010101011
- Video guard band (VGB):
  - ch0 = 1011001100, ch1 = 0100110011, ch2 = 1011001100.
- Island guard band (IGB):
  - ch1 = ch2 = 0100110011; ch0 ignored.
- Sync: in control periods, ch0 {D1,D0} = {vsync, hsync}.
- Preamble CTL word: CTL[3:0] = {ch2 D1, ch2 D0, ch1 D1, ch1 D0}.
  - Video preamble: 0001.
  - Island preamble: 0101.

Preamble counter:
- 4 bits, saturating at `PREAMBLE_LEN`.
- Increments while ch1 and ch2 are control tokens and CTL equals the previous cycle's CTL.
- Reloads to 1 on a CTL change.
- Clears on any non-control character.
- `pre_vid` / `pre_isl` assert when the count equals `PREAMBLE_LEN` and CTL is 0001 / 0101 respectively.

State machine (states CONTROL, VGUARD, VIDEO, IGUARD, ISLAND):
- CONTROL:
  - All three channels control tokens: update sync from ch0; stay.
  - VGB: go to VGUARD.
  - IGB: go to IGUARD.
  - Anything else: `o_err` pulse; stay.
- VGUARD:
  - Second VGB: go to VIDEO.
  - Otherwise: `o_err` pulse, go to CONTROL.
- VIDEO:
  - Control token on ch0: go to CONTROL and take sync from that token.
  - Otherwise each character is a pixel: `o_pv` high.
- IGUARD:
  - Second IGB: go to ISLAND.
  - Otherwise: `o_err` pulse, go to CONTROL.
- ISLAND:
  - Control token on ch1: go to CONTROL.
  - Sync outputs hold their last value throughout.
- Guard characters never produce `o_pv`.
- Sync may change in any cycle where ch0 carries a control token. Sync holds in every other state.

## Timing

- Two-stage pipeline: stage 1 registers the token classification; stage 2 holds the state register and the outputs.
- Input to output latency is exactly 2 clocks for all outputs.
- Reset (asynchronous, any time):
  - State = CONTROL.
  - Preamble counter = 0.
  - Stage-1 flags = 0.
  - `o_hsync` = `o_vsync` = `o_pv` = `o_island` = `o_err` = 0.
- First valid output appears 2 clocks after reset deasserts.
- `o_pv` on the first pixel is high exactly 2 clocks after the first pixel character arrives. It is low on the cycle the ending control token is output.
- A VGB arriving in CONTROL while a preamble is partially counted is handled per Configuration.

## Configuration

`HDMI_PREAMBLE_CHECK_EN`:
- Defined:
  - A VGB is accepted in CONTROL only when `pre_vid` held on the previous character.
  - An IGB is accepted only when `pre_isl` held on the previous character.
  - A guard character seen without the matching preamble: `o_err` pulse, stay in CONTROL.
- Undefined:
  - The preamble counter is removed.
  - Any VGB or IGB in CONTROL begins the corresponding guard state.

## Test plan

- Reset mid-VIDEO (`i_reset` pulsed between edges) -> outputs go to 0 immediately; state is CONTROL; the next pixel characters produce no `o_pv` until a new guard band.
- Control ch0 = 0010101011 (hsync=1) for 4 clocks, then 1101010100 -> `o_hsync` high for 4 cycles, starting 2 clocks after the first token; `o_vsync` stays 0.
- 8× video preamble, 2× VGB, 640 pixel characters, then control 00 -> exactly 640 consecutive `o_pv` cycles; `o_pv` rises 2 clocks after the first pixel; no `o_err`.
- 8× island preamble, 2× IGB, 32 island characters, then control with vsync=1 -> `o_island` high for 32 cycles; `o_vsync` unchanged until the control character, then rises 2 clocks later.
- 1× VGB followed by a control token -> single `o_err` pulse; state is CONTROL; no `o_pv`.
- With `HDMI_PREAMBLE_CHECK_EN`: 7 preamble characters then VGB -> `o_err` pulse and no video. Without the macro, the same stimulus enters VIDEO normally.
